svc_soc_boot_ctrl: RTL and testbench

Boot and lifecycle sequencer for the SoC: it owns the CPU reset and the memory write port, and is fed by a byte stream (UART RX). It parses load frames into IMEM/DMEM word writes, and releases the CPU on a go command. While the CPU runs, it watches for completion or a watchdog expiry and re-arms for the next load, so the test image can be swapped without a full system reset.

---
 rtl/svc_boot_pkg.sv | 28 ++
 rtl/svc_soc_boot_ctrl_if.sv | 23 ++
 rtl/svc_boot_wdog.sv | 31 +++
 rtl/svc_soc_boot_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_svc_soc_boot_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/svc_boot_pkg.sv
// svc_boot_pkg: shared constants for the SoC boot/lifecycle sequencer.
// Holds the FSM state encoding, the command bytes, byte-index widths and a
// small little-endian assembly helper used by the frame parser.
package svc_boot_pkg;

  // Command bytes that open a frame
  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_GO   = 8'h47;  // 'G'

  // Byte-index widths: 4 bytes per address/data word, 2 bytes per length
  localparam int BYTE_IDX_W = 2;
  localparam int LEN_IDX_W  = 1;

  // FSM state encoding (plain constants so older tools can share them)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_LEN   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;
  localparam logic [2:0] ST_RUN   = 3'd6;

  // Shift a new byte in at the top so the first byte ends up least significant
  function automatic logic [31:0] le_shift32(input logic [31:0] acc, input logic [7:0] b);
    return {b, acc[31:8]};
  endfunction

endpackage

// File: rtl/svc_soc_boot_ctrl_if.sv
// svc_soc_boot_ctrl_if: byte-stream input and memory write port of the boot
// sequencer. The master side feeds bytes and observes memory writes; the
// slave side is the sequencer itself.
interface svc_soc_boot_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  s_valid;
  logic [7:0]            s_data;
  logic                  s_ready;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/svc_boot_wdog.sv
// svc_boot_wdog: clear/enable/expire cycle counter. Counts enabled cycles
// from 0 and flags expiry on the cycle the count reaches LIMIT-1. Used both
// for the CPU reset hold time and for the run watchdog.
module svc_boot_wdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_reg;

  // Count enabled cycles, saturating at the last value until cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != LAST)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expire = en && (cnt_reg == LAST);

endmodule

// File: rtl/svc_soc_boot_ctrl.sv
// svc_soc_boot_ctrl: boot and lifecycle sequencer. Parses 'L' load frames
// from a byte stream into 32-bit word writes, releases the CPU from reset on
// 'G', and returns to IDLE when the CPU signals done (or the watchdog fires).
// Optional feature macro: SVC_BOOT_WATCHDOG_EN enables the run watchdog and
// the sticky timeout flag; without it RUN exits only on cpu_done.
module svc_soc_boot_ctrl
  import svc_boot_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 12,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned WATCHDOG_CYCLES = 2_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  svc_soc_boot_ctrl_if.slave      bus,
  output logic                    cpu_rst_n,
  input  logic                    cpu_done,
  output logic                    running,
  output logic                    done,
  output logic                    timeout,
  output logic                    err
);

  logic [2:0]            state_reg, state_next;
  logic [BYTE_IDX_W-1:0] byte_idx_reg;
  logic [31:0]           addr_buf_reg;
  logic [15:0]           len_buf_reg;
  logic [15:0]           remaining_reg;
  logic [ADDR_WIDTH-1:0] word_idx_reg;
  logic [31:0]           data_buf_reg;
  logic                  mem_wen_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [31:0]           mem_wdata_reg;
  logic                  done_reg;
  logic                  err_reg;

  logic                  accept;
  logic [15:0]           count_full;
  logic [31:0]           data_full;
  logic                  hold_expire;
  logic                  wd_expire;

  // Only address bits [ADDR_WIDTH+1:2] select a word; the rest are ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_buf_reg[31:ADDR_WIDTH+2], addr_buf_reg[1:0]};

  assign accept     = bus.s_valid && bus.s_ready;
  assign count_full = {bus.s_data, len_buf_reg[15:8]};
  assign data_full  = le_shift32(data_buf_reg, bus.s_data);

  // Stream is accepted in every parsing state; stalled while writing or while the CPU owns the SoC
  always_comb begin
    bus.s_ready = 1'b0;
    case (state_reg)
      ST_IDLE, ST_ADDR, ST_LEN, ST_DATA: bus.s_ready = 1'b1;
      default:                           bus.s_ready = 1'b0;
    endcase
  end

  // Next-state decode for frame parsing and CPU lifecycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (bus.s_data == CMD_LOAD)    state_next = ST_ADDR;
          else if (bus.s_data == CMD_GO) state_next = ST_HOLD;
          else                           state_next = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (accept && (byte_idx_reg == 2'd3)) state_next = ST_LEN;
      end
      ST_LEN: begin
        if (accept && byte_idx_reg[LEN_IDX_W-1]) begin
          state_next = (count_full == 16'd0) ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept && (byte_idx_reg == 2'd3)) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        state_next = (remaining_reg == 16'd1) ? ST_IDLE : ST_DATA;
      end
      ST_HOLD: begin
        if (hold_expire) state_next = ST_RUN;
      end
      ST_RUN: begin
        // cpu_done takes priority over a coincident watchdog expiry
        if (cpu_done || wd_expire) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame assembly, write strobe generation and sticky status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      byte_idx_reg  <= '0;
      addr_buf_reg  <= '0;
      len_buf_reg   <= '0;
      remaining_reg <= '0;
      word_idx_reg  <= '0;
      data_buf_reg  <= '0;
      mem_wen_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mem_wen_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            byte_idx_reg <= '0;
            if (bus.s_data == CMD_GO) begin
              done_reg <= 1'b0;
            end else if (bus.s_data != CMD_LOAD) begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (accept) begin
            addr_buf_reg <= le_shift32(addr_buf_reg, bus.s_data);
            byte_idx_reg <= byte_idx_reg + 1'b1;
          end
        end
        ST_LEN: begin
          if (accept) begin
            len_buf_reg <= count_full;
            if (byte_idx_reg[LEN_IDX_W-1]) begin
              remaining_reg <= count_full;
              word_idx_reg  <= '0;
              byte_idx_reg  <= '0;
            end else begin
              byte_idx_reg <= byte_idx_reg + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            data_buf_reg <= data_full;
            byte_idx_reg <= byte_idx_reg + 1'b1;
            if (byte_idx_reg == 2'd3) begin
              mem_wen_reg   <= 1'b1;
              mem_addr_reg  <= addr_buf_reg[ADDR_WIDTH+1:2] + word_idx_reg;
              mem_wdata_reg <= data_full;
            end
          end
        end
        ST_WRITE: begin
          word_idx_reg  <= word_idx_reg + 1'b1;
          remaining_reg <= remaining_reg - 16'd1;
        end
        ST_RUN: begin
          if (cpu_done) done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // CPU reset hold timer: runs only while in HOLD
  svc_boot_wdog #(
    .LIMIT (RST_HOLD_CYCLES)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_reg != ST_HOLD),
    .en     (state_reg == ST_HOLD),
    .expire (hold_expire)
  );

`ifdef SVC_BOOT_WATCHDOG_EN
  logic timeout_reg;

  svc_boot_wdog #(
    .LIMIT (WATCHDOG_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_reg != ST_RUN),
    .en     (state_reg == ST_RUN),
    .expire (wd_expire)
  );

  // Sticky timeout: cleared by go, set when a run ends on expiry without cpu_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_reg <= 1'b0;
    end else if ((state_reg == ST_IDLE) && accept && (bus.s_data == CMD_GO)) begin
      timeout_reg <= 1'b0;
    end else if ((state_reg == ST_RUN) && wd_expire && !cpu_done) begin
      timeout_reg <= 1'b1;
    end
  end

  assign timeout = timeout_reg;
`else
  localparam int unsigned unused_wd_cycles = WATCHDOG_CYCLES;
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign bus.mem_wen   = mem_wen_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign cpu_rst_n     = (state_reg == ST_RUN);
  assign running       = (state_reg == ST_RUN);
  assign done          = done_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_svc_soc_boot_ctrl.sv
// tb_svc_soc_boot_ctrl: directed, table-driven bench for the boot sequencer.
// Load frames come from a vector table; go/run/watchdog/reset sequences are
// hand-written. Watchdog checks depend on SVC_BOOT_WATCHDOG_EN.
module tb_svc_soc_boot_ctrl;
  import svc_boot_pkg::*;

  localparam int AW   = 12;
  localparam int HOLD = 16;
  localparam int WD   = 50;
`ifdef SVC_BOOT_WATCHDOG_EN
  localparam int DONE_AT = 40;
`else
  localparam int DONE_AT = 100;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_done = 1'b0;
  logic cpu_rst_n, running, done, timeout, err;

  svc_soc_boot_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  svc_soc_boot_ctrl #(
    .ADDR_WIDTH      (AW),
    .RST_HOLD_CYCLES (HOLD),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cpu_rst_n (cpu_rst_n),
    .cpu_done  (cpu_done),
    .running   (running),
    .done      (done),
    .timeout   (timeout),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Captured writes: {addr, data}
  logic [AW+31:0] wq[$];
  always @(negedge clk) if (bus.mem_wen === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});

  typedef struct {
    logic [31:0]   addr;
    int            cnt;
    logic [31:0]   w0;
    logic [31:0]   w1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (bus.s_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      $display("FAIL ready_wait: s_ready=%b after %0d cycles, need 1", bus.s_ready, guard);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  // Send one data word; check the write strobe and the one-cycle stall
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    check("wen_after_word", {bus.mem_wen, bus.s_ready}, 2'b10);
    @(posedge clk); #1;
    check("ready_back", {bus.mem_wen, bus.s_ready}, 2'b01);
  endtask

  task automatic send_frame(input vec_t v, input int idx);
    logic [15:0] c;
    logic [AW+31:0] e;
    c = 16'(v.cnt);
    wq.delete();
    send_byte(CMD_LOAD);
    for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8]);
    send_byte(c[7:0]);
    send_byte(c[15:8]);
    if (v.cnt >= 1) send_word(v.w0);
    if (v.cnt >= 2) send_word(v.w1);
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("v%0d_nwrites", idx), 64'(wq.size()), 64'(v.cnt));
    if (v.cnt >= 1 && wq.size() >= 1) begin
      e = wq.pop_front();
      check($sformatf("v%0d_addr0", idx), 64'(e[AW+31:32]), 64'(v.a0));
      check($sformatf("v%0d_data0", idx), 64'(e[31:0]), 64'(v.w0));
    end
    if (v.cnt >= 2 && wq.size() >= 1) begin
      e = wq.pop_front();
      check($sformatf("v%0d_addr1", idx), 64'(e[AW+31:32]), 64'(v.a1));
      check($sformatf("v%0d_data1", idx), 64'(e[31:0]), 64'(v.w1));
    end
    check($sformatf("v%0d_idle_ready", idx), 64'(bus.s_ready), 64'd1);
  endtask

  // Wait out the HOLD phase; returns number of cycles cpu_rst_n stayed low
  task automatic wait_hold(output int n);
    n = 0;
    while (cpu_rst_n !== 1'b1 && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  // Compare every reset-valued output at once
  task automatic check_reset_outputs(input string name);
    check(name, {cpu_rst_n, bus.mem_wen, 64'(bus.mem_addr), bus.mem_wdata, running, done, timeout, err, bus.s_ready},
          {1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    int n;
    int high_cnt;

    vecs[0] = '{addr: 32'h0000_0010, cnt: 2, w0: 32'h1122_3344, w1: 32'hAABB_CCDD, a0: 12'h004, a1: 12'h005};
    vecs[1] = '{addr: 32'h0000_3FFC, cnt: 2, w0: 32'hCAFE_F00D, w1: 32'h0102_0304, a0: 12'hFFF, a1: 12'h000};
    vecs[2] = '{addr: 32'h0000_0103, cnt: 1, w0: 32'hDEAD_BEEF, w1: 32'h0,         a0: 12'h040, a1: 12'h000};
    vecs[3] = '{addr: 32'h1234_5678, cnt: 0, w0: 32'h0,         w1: 32'h0,         a0: 12'h000, a1: 12'h000};
    vecs[4] = '{addr: 32'hFFFF_FFF8, cnt: 2, w0: 32'h5A5A_A5A5, w1: 32'h0000_0001, a0: 12'hFFE, a1: 12'hFFF};

    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_low");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_release");

    // Unknown command byte: err set, stays in IDLE
    send_byte(8'h00);
    check("err_set", {err, bus.s_ready, running}, 3'b110);
    @(posedge clk); #1;
    check("err_idle", {err, bus.s_ready, cpu_rst_n}, 3'b110);

    for (int i = 0; i < 5; i++) send_frame(vecs[i], i);

    // Go, hold, run until cpu_done
    send_byte(CMD_GO);
    check("hold_ready", {bus.s_ready, cpu_rst_n, running}, 3'b000);
    wait_hold(n);
    check("hold_cycles", 64'(n), 64'(HOLD));
    check("running_on", 64'(running), 64'd1);
    high_cnt = 1;
    for (int i = 1; i < DONE_AT; i++) begin
      @(posedge clk); #1;
      if (cpu_rst_n === 1'b1) high_cnt++;
    end
    cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
    check("run_high_cycles", 64'(high_cnt), 64'(DONE_AT));
    check("done_end", {cpu_rst_n, done, running, timeout, bus.s_ready}, 5'b01001);

    // Second go clears done
    send_byte(CMD_GO);
    check("go_clears_done", 64'(done), 64'd0);
    wait_hold(n);
    check("hold_cycles2", 64'(n), 64'(HOLD));
`ifdef SVC_BOOT_WATCHDOG_EN
    n = 1;
    while (cpu_rst_n === 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      if (cpu_rst_n === 1'b1) n++;
    end
    check("wd_run_cycles", 64'(n), 64'(WD));
    check("wd_timeout", {timeout, done, running}, 3'b100);
    send_byte(CMD_GO);
    check("go_clears_timeout", 64'(timeout), 64'd0);
    wait_hold(n);
    // cpu_done on the exact expiry cycle: done wins
    repeat (WD - 1) @(posedge clk);
    #1;
    cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
    check("done_wins", {done, timeout, cpu_rst_n}, 3'b100);
`else
    repeat (60) @(posedge clk);
    #1;
    check("no_wd_still_running", {running, timeout}, 2'b10);
    cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
    check("no_wd_done", {done, running, timeout}, 3'b100);
`endif

    // Reset mid-frame after two data bytes
    wq.delete();
    send_byte(CMD_LOAD);
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h77); send_byte(8'h66);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midframe_no_write", 64'(wq.size()), 64'd0);
    check_reset_outputs("after_reset_idle");
    send_frame(vecs[0], 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #500000;
    $display("FAIL global_timeout: sim time %0t, limit reached", $time);
    $fatal(1, "time limit");
  end

endmodule
